reg_file: RTL and testbench

//  Register file for the 8-bit datapath. Sits directly upstream of the 2:1 operand mux:
//  OUT1 feeds the ALU directly, and OUT2 feeds the mux in0 leg.
//  One synchronous write port and two asynchronous read ports.

---
 rtl/reg_file.sv | 52 +++++
 tb/tb_reg_file.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 8 x 8-bit register file: one synchronous write port, two combinational reads.
// Writes are held off while the memory stage reports BUSYWAIT.
module reg_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              wr_zero;

    assign wr_zero = ZERO_REG && (INADDRESS == '0);
    assign wr_en   = WRITE && !BUSYWAIT && !wr_zero;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[INADDRESS] <= IN;
        end
    end

    // No bypass: a read of the address being written shows the old value
    // until the edge commits the new one.
    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        OUT2 = regs[OUT2ADDRESS];
        if (ZERO_REG && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
        if (ZERO_REG && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: table of write/read vectors plus hand-built corner sequences.
// Two instances share stimulus: ordinary register 0 and hard-wired-zero register 0.
`timescale 1ns/100ps
module tb_reg_file;

    logic       clk = 1'b0;
    logic       RESET;
    logic       WRITE;
    logic       BUSYWAIT;
    logic [2:0] INADDRESS;
    logic [7:0] IN;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1, OUT2;
    logic [7:0] zout1, zout2;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] z1;
        logic [7:0] z2;
    } exp_t;

    typedef struct packed {
        logic       wr;
        logic       bw;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] z1;
        logic [7:0] z2;
    } vec_t;

    exp_t  sb[$];
    string nq[$];
    vec_t  vecs[7];

    always #5 clk = ~clk;

    reg_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut (
        .CLK(clk), .RESET(RESET), .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
        .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(OUT1), .OUT2(OUT2)
    );

    reg_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dutz (
        .CLK(clk), .RESET(RESET), .WRITE(WRITE), .BUSYWAIT(BUSYWAIT),
        .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(zout1), .OUT2(zout2)
    );

    task automatic cmp(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic push(input string n, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] z1,
                        input logic [7:0] z2);
        sb.push_back('{e1: e1, e2: e2, z1: z1, z2: z2});
        nq.push_back(n);
    endtask

    task automatic sb_check();
        exp_t  e;
        string n;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue want entry");
            return;
        end
        e = sb.pop_front();
        n = nq.pop_front();
        cmp({n, ".out1"}, OUT1, e.e1);
        cmp({n, ".out2"}, OUT2, e.e2);
        cmp({n, ".zout1"}, zout1, e.z1);
        cmp({n, ".zout2"}, zout2, e.z2);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        WRITE       = v.wr;
        BUSYWAIT    = v.bw;
        INADDRESS   = v.wa;
        IN          = v.wd;
        OUT1ADDRESS = v.a1;
        OUT2ADDRESS = v.a2;
        push($sformatf("vec%0d", idx), v.e1, v.e2, v.z1, v.z2);
        @(posedge clk);
        #1;
        sb_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] z0;

        //           wr   bw   wa    wd     a1    a2    e1     e2     z1     z2
        vecs[0] = '{1'b1,1'b0,3'd3,8'h3C,3'd3,3'd5,8'h3C,8'h00,8'h3C,8'h00};
        vecs[1] = '{1'b1,1'b0,3'd5,8'hC3,3'd3,3'd5,8'h3C,8'hC3,8'h3C,8'hC3};
        vecs[2] = '{1'b1,1'b1,3'd3,8'hFF,3'd3,3'd3,8'h3C,8'h3C,8'h3C,8'h3C};
        vecs[3] = '{1'b0,1'b0,3'd5,8'h00,3'd5,3'd3,8'hC3,8'h3C,8'hC3,8'h3C};
        vecs[4] = '{1'b1,1'b0,3'd0,8'h99,3'd0,3'd5,8'h99,8'hC3,8'h00,8'hC3};
        vecs[5] = '{1'b1,1'b0,3'd7,8'h80,3'd7,3'd0,8'h80,8'h99,8'h80,8'h00};
        vecs[6] = '{1'b1,1'b0,3'd1,8'h01,3'd1,3'd1,8'h01,8'h01,8'h01,8'h01};

        RESET = 1'b1;
        WRITE = 1'b0;
        BUSYWAIT = 1'b0;
        INADDRESS = '0;
        IN = '0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd7;
        #2;
        push("reset_state", 8'h00, 8'h00, 8'h00, 8'h00);
        sb_check();
        @(negedge clk);
        RESET = 1'b0;

        // Fill every register with A5, then clear them with a mid-cycle pulse.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            WRITE = 1'b1;
            INADDRESS = 3'(i);
            IN = 8'hA5;
            OUT1ADDRESS = 3'(i);
            OUT2ADDRESS = 3'(i);
            z0 = (i == 0) ? 8'h00 : 8'hA5;
            push($sformatf("load_r%0d", i), 8'hA5, 8'hA5, z0, z0);
            @(posedge clk);
            #1;
            sb_check();
        end
        @(negedge clk);
        WRITE = 1'b0;
        @(posedge clk);
        #1;
        RESET = 1'b1;
        OUT1ADDRESS = 3'd6;
        OUT2ADDRESS = 3'd7;
        #0.5;
        push("midreset_high", 8'h00, 8'h00, 8'h00, 8'h00);
        sb_check();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OUT1ADDRESS = 3'(2 * i);
            OUT2ADDRESS = 3'(2 * i + 1);
            #0.5;
            push($sformatf("midreset_pair%0d", i), 8'h00, 8'h00, 8'h00, 8'h00);
            sb_check();
        end

        for (int i = 0; i < 7; i++) begin
            apply(i, vecs[i]);
        end

        // Read ports follow address changes with no edge.
        @(negedge clk);
        WRITE = 1'b0;
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd5;
        #1;
        push("comb_read", 8'h3C, 8'hC3, 8'h3C, 8'hC3);
        sb_check();

        // Stall for three edges, then release.
        @(negedge clk);
        WRITE = 1'b1;
        BUSYWAIT = 1'b1;
        INADDRESS = 3'd2;
        IN = 8'h77;
        OUT1ADDRESS = 3'd2;
        OUT2ADDRESS = 3'd2;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("stall%0d", i), 8'h00, 8'h00, 8'h00, 8'h00);
            @(posedge clk);
            #1;
            sb_check();
        end
        @(negedge clk);
        BUSYWAIT = 1'b0;
        push("stall_release", 8'h77, 8'h77, 8'h77, 8'h77);
        @(posedge clk);
        #1;
        sb_check();

        // Read during write on the same address.
        @(negedge clk);
        INADDRESS = 3'd4;
        IN = 8'h11;
        OUT1ADDRESS = 3'd2;
        OUT2ADDRESS = 3'd4;
        @(posedge clk);
        @(negedge clk);
        IN = 8'h22;
        #1;
        push("rdw_before", 8'h77, 8'h11, 8'h77, 8'h11);
        sb_check();
        push("rdw_after", 8'h77, 8'h22, 8'h77, 8'h22);
        @(posedge clk);
        #1;
        sb_check();

        // Reset wins over a write at the same edge; write lands right after.
        @(negedge clk);
        RESET = 1'b1;
        INADDRESS = 3'd3;
        IN = 8'hFF;
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd4;
        push("reset_vs_write", 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        sb_check();
        @(negedge clk);
        RESET = 1'b0;
        push("first_write_after_reset", 8'hFF, 8'h00, 8'hFF, 8'h00);
        @(posedge clk);
        #1;
        sb_check();
        @(negedge clk);
        WRITE = 1'b0;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
